// File: rtl/vx_mem_bus_serializer.sv
// Splits one wide Vortex memory request into narrow bus beats and gathers read beats into a wide response.
// Optional macro VX_SERIALIZER_SKIP_EMPTY_BEATS_EN: skip write beats whose byte-enable slice is all zero.
module vx_mem_bus_serializer #(
    parameter int MEM_DATA_WIDTH = 512,
    parameter int MEM_ADDR_WIDTH = 26,
    parameter int MEM_TAG_WIDTH  = 56,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 32,
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                        clk,
    input  logic                        nRST,
    input  logic                        mem_req_valid,
    input  logic                        mem_req_rw,
    input  logic [MEM_DATA_WIDTH/8-1:0] mem_req_byteen,
    input  logic [MEM_ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_req_data,
    input  logic [MEM_TAG_WIDTH-1:0]    mem_req_tag,
    output logic                        mem_req_ready,
    output logic                        mem_rsp_valid,
    output logic [MEM_DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [MEM_TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                        mem_rsp_ready,
    output logic                        bus_wen,
    output logic                        bus_ren,
    output logic [BUS_ADDR_WIDTH-1:0]   bus_addr,
    output logic [BUS_DATA_WIDTH-1:0]   bus_wdata,
    output logic [BUS_DATA_WIDTH/8-1:0] bus_strobe,
    input  logic [BUS_DATA_WIDTH-1:0]   bus_rdata,
    input  logic                        bus_request_stall,
    input  logic                        bus_error,
    output logic                        busy,
    output logic                        err_sticky
);

    localparam int BEATS     = MEM_DATA_WIDTH / BUS_DATA_WIDTH;
    localparam int MEM_BYTES = MEM_DATA_WIDTH / 8;
    localparam int BUS_BYTES = BUS_DATA_WIDTH / 8;
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BUS_ADDR_WIDTH-1:0] LINE_STEP = BUS_ADDR_WIDTH'(MEM_BYTES);
    localparam logic [BUS_ADDR_WIDTH-1:0] BEAT_STEP = BUS_ADDR_WIDTH'(BUS_BYTES);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [BUS_ADDR_WIDTH-1:0]   base_q;
    logic [MEM_DATA_WIDTH-1:0]   data_q;
    logic [MEM_BYTES-1:0]        byteen_q;
    logic [MEM_TAG_WIDTH-1:0]    tag_q;
    logic [MEM_DATA_WIDTH-1:0]   rsp_buf;
    logic                        err_q;

    logic beat_active;
    logic last_beat;

    assign beat_active = (state == WRITE) || (state == READ);
    assign last_beat   = (cnt == CNT_W'(BEATS - 1));

`ifdef VX_SERIALIZER_SKIP_EMPTY_BEATS_EN
    logic             first_found;
    logic [CNT_W-1:0] first_idx;
    logic             next_found;
    logic [CNT_W-1:0] next_idx;

    // Descending scan so the lowest non-empty slice wins.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int unsigned i = BEATS; i > 0; i--) begin
            if (|mem_req_byteen[(i-1)*BUS_BYTES +: BUS_BYTES]) begin
                first_found = 1'b1;
                first_idx   = CNT_W'(i - 1);
            end
            if (((i - 1) > 32'(cnt)) && (|byteen_q[(i-1)*BUS_BYTES +: BUS_BYTES])) begin
                next_found = 1'b1;
                next_idx   = CNT_W'(i - 1);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            cnt      <= '0;
            base_q   <= '0;
            data_q   <= '0;
            byteen_q <= '0;
            tag_q    <= '0;
            rsp_buf  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (beat_active && !bus_request_stall && bus_error) begin
                err_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mem_req_valid) begin
                        base_q   <= BASE_ADDR + BUS_ADDR_WIDTH'(mem_req_addr) * LINE_STEP;
                        data_q   <= mem_req_data;
                        byteen_q <= mem_req_byteen;
                        tag_q    <= mem_req_tag;
                        cnt      <= '0;
                        if (mem_req_rw) begin
`ifdef VX_SERIALIZER_SKIP_EMPTY_BEATS_EN
                            if (first_found) begin
                                cnt   <= first_idx;
                                state <= WRITE;
                            end
`else
                            state <= WRITE;
`endif
                        end else begin
                            state <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (!bus_request_stall) begin
`ifdef VX_SERIALIZER_SKIP_EMPTY_BEATS_EN
                        if (next_found) begin
                            cnt <= next_idx;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
`else
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                end
                READ: begin
                    if (!bus_request_stall) begin
                        rsp_buf[cnt*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_rdata;
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= RESP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (mem_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req_ready = (state == IDLE);
    assign mem_rsp_valid = (state == RESP);
    assign mem_rsp_data  = rsp_buf;
    assign mem_rsp_tag   = tag_q;
    assign busy          = (state != IDLE);
    assign err_sticky    = err_q;

    assign bus_wen    = (state == WRITE);
    assign bus_ren    = (state == READ);
    assign bus_addr   = beat_active ? (base_q + BUS_ADDR_WIDTH'(cnt) * BEAT_STEP) : '0;
    assign bus_wdata  = bus_wen ? data_q[cnt*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] : '0;
    assign bus_strobe = bus_wen ? byteen_q[cnt*BUS_BYTES +: BUS_BYTES] :
                        (bus_ren ? '1 : '0);

endmodule

// File: tb/tb_vx_mem_bus_serializer.sv
// Directed, table-driven bench for vx_mem_bus_serializer at default parameters (16 beats of 32 bits).
module tb_vx_mem_bus_serializer;

    localparam int BEATS = 16;

    logic         clk = 1'b0;
    logic         nRST;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [63:0]  mem_req_byteen;
    logic [25:0]  mem_req_addr;
    logic [511:0] mem_req_data;
    logic [55:0]  mem_req_tag;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [511:0] mem_rsp_data;
    logic [55:0]  mem_rsp_tag;
    logic         mem_rsp_ready;
    logic         bus_wen;
    logic         bus_ren;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [3:0]   bus_strobe;
    logic [31:0]  bus_rdata;
    logic         bus_request_stall;
    logic         bus_error;
    logic         busy;
    logic         err_sticky;

    always #5 clk = ~clk;

    vx_mem_bus_serializer #(
        .MEM_DATA_WIDTH(512),
        .MEM_ADDR_WIDTH(26),
        .MEM_TAG_WIDTH (56),
        .BUS_DATA_WIDTH(32),
        .BUS_ADDR_WIDTH(32),
        .BASE_ADDR     (32'h0)
    ) dut (
        .clk              (clk),
        .nRST             (nRST),
        .mem_req_valid    (mem_req_valid),
        .mem_req_rw       (mem_req_rw),
        .mem_req_byteen   (mem_req_byteen),
        .mem_req_addr     (mem_req_addr),
        .mem_req_data     (mem_req_data),
        .mem_req_tag      (mem_req_tag),
        .mem_req_ready    (mem_req_ready),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_data     (mem_rsp_data),
        .mem_rsp_tag      (mem_rsp_tag),
        .mem_rsp_ready    (mem_rsp_ready),
        .bus_wen          (bus_wen),
        .bus_ren          (bus_ren),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_strobe       (bus_strobe),
        .bus_rdata        (bus_rdata),
        .bus_request_stall(bus_request_stall),
        .bus_error        (bus_error),
        .busy             (busy),
        .err_sticky       (err_sticky)
    );

    typedef struct {
        logic        rw;
        logic [25:0] addr;
        logic [55:0] tag;
        logic [15:0] word_en;     // per 32-bit word byte-enable (all four bytes)
        logic [31:0] dbase;       // word i of write data / read data = dbase + i
        int          stall_beat;  // -1 = none
        int          stall_len;
        int          err_beat;    // -1 = none
        int          hold;        // cycles mem_rsp_ready stays low in RESP
        int          abort_beat;  // -1 = none; assert nRST while this beat is on the bus
        logic [31:0] addr0;       // hand-computed byte address of beat 0
    } vec_t;

    vec_t vecs[9];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_err  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_req_ready"}, 64'(mem_req_ready), 64'(1));
        chk({nm, "_wen"},       64'(bus_wen),       64'(0));
        chk({nm, "_ren"},       64'(bus_ren),       64'(0));
        chk({nm, "_addr"},      64'(bus_addr),      64'(0));
        chk({nm, "_strobe"},    64'(bus_strobe),    64'(0));
        chk({nm, "_wdata"},     64'(bus_wdata),     64'(0));
        chk({nm, "_rsp_valid"}, 64'(mem_rsp_valid), 64'(0));
        chk({nm, "_err"},       64'(err_sticky),    64'(0));
        chk({nm, "_busy"},      64'(busy),          64'(0));
    endtask

    task automatic chk_rsp(input string nm, input vec_t v);
        chk({nm, "_valid"}, 64'(mem_rsp_valid), 64'(1));
        chk({nm, "_ready"}, 64'(mem_req_ready), 64'(0));
        chk({nm, "_tag"},   64'(mem_rsp_tag),   64'(v.tag));
        for (int w = 0; w < BEATS; w++) begin
            chk({nm, "_word"}, 64'(mem_rsp_data[w*32 +: 32]), 64'(v.dbase + 32'(w)));
        end
    endtask

    task automatic run_txn(input vec_t v);
        int   i;
        int   sc;
        logic stall;
        logic [3:0] exp_strb;

        mem_rsp_ready = (v.hold == 0) && !v.rw;
        chk("idle_ready", 64'(mem_req_ready), 64'(1));
        mem_req_valid = 1'b1;
        mem_req_rw    = v.rw;
        mem_req_addr  = v.addr;
        mem_req_tag   = v.tag;
        for (int w = 0; w < BEATS; w++) begin
            mem_req_data[w*32 +: 32]  = v.dbase + 32'(w);
            mem_req_byteen[w*4 +: 4]  = v.word_en[w] ? 4'hF : 4'h0;
        end
        @(posedge clk);
        @(negedge clk);
        // scramble request inputs to prove the DUT latched them
        mem_req_valid  = 1'b0;
        mem_req_rw     = ~v.rw;
        mem_req_addr   = 26'($urandom);
        mem_req_tag    = 56'({$urandom, $urandom});
        mem_req_data   = {16{$urandom}};
        mem_req_byteen = {$urandom, $urandom};

        i  = 0;
        sc = 0;
        while (i < BEATS) begin
`ifdef VX_SERIALIZER_SKIP_EMPTY_BEATS_EN
            if (v.rw && !v.word_en[i]) begin
                i++;
                continue;
            end
`endif
            if (i == v.abort_beat) begin
                nRST = 1'b0;
                #1;
                chk_reset_outputs("abort");
                exp_err       = 1'b0;
                mem_rsp_ready = 1'b0;
                @(posedge clk);
                @(negedge clk);
                nRST = 1'b1;
                return;
            end
            stall = (i == v.stall_beat) && (sc < v.stall_len);
            if (stall) sc++;
            exp_strb = v.rw ? (v.word_en[i] ? 4'hF : 4'h0) : 4'hF;
            chk("beat_wen",    64'(bus_wen),       64'(v.rw));
            chk("beat_ren",    64'(bus_ren),       64'(!v.rw));
            chk("beat_ready",  64'(mem_req_ready), 64'(0));
            chk("beat_busy",   64'(busy),          64'(1));
            chk("beat_addr",   64'(bus_addr),      64'(v.addr0 + 32'(i * 4)));
            chk("beat_strobe", 64'(bus_strobe),    64'(exp_strb));
            if (v.rw) chk("beat_wdata", 64'(bus_wdata), 64'(v.dbase + 32'(i)));
            chk("beat_err",    64'(err_sticky),    64'(exp_err));
            bus_request_stall = stall;
            bus_rdata         = v.dbase + 32'(i);
            bus_error         = (i == v.err_beat) && !stall;
            @(posedge clk);
            if (bus_error) exp_err = 1'b1;
            @(negedge clk);
            bus_error         = 1'b0;
            bus_request_stall = 1'b0;
            bus_rdata         = $urandom;
            if (!stall) i++;
        end

        chk("end_err", 64'(err_sticky), 64'(exp_err));
        if (v.rw) begin
            chk("wr_done_ready", 64'(mem_req_ready), 64'(1));
            chk("wr_done_wen",   64'(bus_wen),       64'(0));
            chk("wr_no_rsp",     64'(mem_rsp_valid), 64'(0));
        end else begin
            chk_rsp("rsp", v);
            chk("rsp_ren", 64'(bus_ren), 64'(0));
            for (int h = 0; h < v.hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                chk_rsp("rsp_hold", v);
            end
            mem_rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            mem_rsp_ready = 1'b0;
            chk("rsp_done_ready", 64'(mem_req_ready), 64'(1));
            chk("rsp_done_valid", 64'(mem_rsp_valid), 64'(0));
        end
    endtask

    initial begin
        //            rw    addr          tag              word_en   dbase          stb stl err hold abort addr0
        vecs[0] = '{1'b1, 26'h1,       56'h0,            16'hFFFF, 32'h0,          -1, 0, -1, 0, -1, 32'h40};
        vecs[1] = '{1'b0, 26'h2,       56'hAB,           16'hFFFF, 32'hD0,          5, 2, -1, 3, -1, 32'h80};
        vecs[2] = '{1'b0, 26'h5,       56'h12345,        16'hFFFF, 32'h1000,       -1, 0,  3, 0, -1, 32'h140};
        vecs[3] = '{1'b1, 26'h3FFFFFF, 56'h0,            16'hFFFF, 32'hCAFE0000,   15, 1, -1, 0, -1, 32'hFFFFFFC0};
        vecs[4] = '{1'b1, 26'h10,      56'h0,            16'h8001, 32'h55,         -1, 0, -1, 0, -1, 32'h400};
        vecs[5] = '{1'b1, 26'h11,      56'h0,            16'h0000, 32'h99,         -1, 0, -1, 0, -1, 32'h440};
        vecs[6] = '{1'b0, 26'h3FFFFFF, 56'hFFFFFFFFFFFFFF, 16'hFFFF, 32'hFFFFFF00,  0, 3, -1, 1, -1, 32'hFFFFFFC0};
        vecs[7] = '{1'b1, 26'h20,      56'h0,            16'hFFFF, 32'h700,        -1, 0, -1, 0,  7, 32'h800};
        vecs[8] = '{1'b0, 26'h21,      56'h77,           16'hFFFF, 32'hD0,         -1, 0, -1, 0, -1, 32'h840};

        nRST              = 1'b0;
        mem_rsp_ready     = 1'b0;
        bus_error         = 1'b0;
        bus_request_stall = 1'b0;
        bus_rdata         = '0;
        for (int k = 0; k < 4; k++) begin
            mem_req_valid     = 1'($urandom);
            mem_req_rw        = 1'($urandom);
            mem_req_addr      = 26'($urandom);
            mem_req_tag       = 56'({$urandom, $urandom});
            mem_req_data      = {16{$urandom}};
            mem_req_byteen    = {$urandom, $urandom};
            mem_rsp_ready     = 1'($urandom);
            bus_rdata         = $urandom;
            bus_request_stall = 1'($urandom);
            bus_error         = 1'($urandom);
            #1;
            chk_reset_outputs("reset");
            @(negedge clk);
        end
        mem_req_valid     = 1'b0;
        mem_rsp_ready     = 1'b0;
        bus_error         = 1'b0;
        bus_request_stall = 1'b0;
        nRST              = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 9; t++) begin
            run_txn(vecs[t]);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
